// File: rtl/vga_pixel_fetch_if.sv
// Pixel-fetch bus: timing-stage request/pixel signals plus the frame-buffer read port.
// master = timing stage and memory side, slave = vga_pixel_fetch.
interface vga_pixel_fetch_if #(
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 12
) ();
  logic              frame_start;
  logic              pix_req;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_valid;
  logic              underflow;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_rdata;

  modport master (
    output frame_start, pix_req, mem_rdata,
    input  pix_data, pix_valid, underflow, mem_rd, mem_addr
  );

  modport slave (
    input  frame_start, pix_req, mem_rdata,
    output pix_data, pix_valid, underflow, mem_rd, mem_addr
  );
endinterface

// File: rtl/vga_pixel_fetch.sv
// Raster-order frame-buffer prefetch into a small FIFO, one registered pixel per request.
// Reads are credit-limited so FIFO plus in-flight never exceeds DEPTH.
module vga_pixel_fetch #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int ADDR_W   = 19,
  parameter int PIX_W    = 12,
  parameter int DEPTH    = 16,
  parameter int MEM_LAT  = 2
) (
  input logic              MAX10_CLK1_50,
  input logic              RESET_N,
  vga_pixel_fetch_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int INF_W = $clog2(MEM_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [MEM_LAT-1:0] pipe;
  logic [INF_W-1:0]  inflight;
  logic [PIX_W-1:0]  fifo [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    committed;
  logic              issue;
  logic              push;
  logic              pop;
  logic              empty;

  // mem_rd is combinational so it is low in the frame_start cycle and rises one cycle later.
  always_comb begin
    committed = (CNT_W+1)'(count) + (CNT_W+1)'(inflight);
    empty     = (count == '0);
    issue     = (state == FETCH) && !bus.frame_start && (committed < (CNT_W+1)'(DEPTH));
    push      = pipe[MEM_LAT-1] && !bus.frame_start;
    pop       = bus.pix_req && !bus.frame_start && !empty;
  end

  assign bus.mem_rd   = issue;
  assign bus.mem_addr = addr;

  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= IDLE;
      addr          <= '0;
      pipe          <= '0;
      inflight      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.pix_data  <= '0;
      bus.pix_valid <= 1'b0;
      bus.underflow <= 1'b0;
    end else if (bus.frame_start) begin
      state         <= FETCH;
      addr          <= '0;
      pipe          <= '0;
      inflight      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.pix_data  <= '0;
      bus.pix_valid <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      pipe     <= (pipe << 1) | MEM_LAT'(issue);
      inflight <= inflight + INF_W'(issue) - INF_W'(pipe[MEM_LAT-1]);
      if (issue) begin
        addr <= addr + ADDR_W'(1);
        if (addr == LAST_ADDR) state <= DONE;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count         <= count + CNT_W'(push) - CNT_W'(pop);
      bus.pix_valid <= pop;
      bus.pix_data  <= pop ? fifo[rd_ptr] : '0;
      if (bus.pix_req && empty) bus.underflow <= 1'b1;
    end
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (push) fifo[wr_ptr] <= bus.mem_rdata;
  end

  fifo_no_overflow: assert property (@(posedge MAX10_CLK1_50) disable iff (!RESET_N)
    !(push && !pop && count == CNT_W'(DEPTH)));

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch on a reduced 40x30 frame: a read-port model returning addr[11:0],
// an arrival-time reference model checked every cycle, and directed/randomized scenarios.
module tb_vga_pixel_fetch;
  localparam int H     = 40;
  localparam int V     = 30;
  localparam int TOTAL = H * V;
  localparam int AW    = 19;
  localparam int PW    = 12;
  localparam int DEPTH = 16;
  localparam int LAT   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_pixel_fetch_if #(.ADDR_W(AW), .PIX_W(PW)) bus ();

  vga_pixel_fetch #(
    .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .PIX_W(PW), .DEPTH(DEPTH), .MEM_LAT(LAT)
  ) dut (
    .MAX10_CLK1_50(clk),
    .RESET_N      (rst_n),
    .bus          (bus)
  );

  // Read port: data for a strobe in cycle c is presented during cycle c+LAT, junk otherwise.
  logic          mem_v [LAT] = '{default: 1'b0};
  logic [AW-1:0] mem_a [LAT] = '{default: '0};
  logic [PW-1:0] junk = '0;
  always @(posedge clk) begin
    mem_v[0] <= bus.mem_rd;
    mem_a[0] <= bus.mem_addr;
    for (int i = 1; i < LAT; i++) begin
      mem_v[i] <= mem_v[i-1];
      mem_a[i] <= mem_a[i-1];
    end
    junk <= PW'($urandom);
  end
  assign bus.mem_rdata = mem_v[LAT-1] ? mem_a[LAT-1][PW-1:0] : junk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: reads issued while outstanding (issued - consumed) < DEPTH; each read's data
  // becomes poppable LAT+1 cycles after its strobe; pixel k of the frame carries k[11:0].
  bit            m_fetch  = 0;
  int            m_issued = 0;
  int            m_popped = 0;
  int            m_cyc    = 0;
  int            m_land[$];
  logic          m_valid  = 1'b0;
  logic [PW-1:0] m_data   = '0;
  logic          m_uf     = 1'b0;

  always @(negedge clk) begin
    bit exp_rd;
    m_cyc++;
    if (!rst_n) begin
      check("rst_mem_rd",    bus.mem_rd,    0);
      check("rst_mem_addr",  bus.mem_addr,  0);
      check("rst_pix_valid", bus.pix_valid, 0);
      check("rst_pix_data",  bus.pix_data,  0);
      check("rst_underflow", bus.underflow, 0);
      m_fetch = 0; m_issued = 0; m_popped = 0; m_land.delete();
      m_valid = 1'b0; m_data = '0; m_uf = 1'b0;
    end else begin
      exp_rd = m_fetch && !bus.frame_start && (m_issued < TOTAL) && ((m_issued - m_popped) < DEPTH);
      check("mem_rd", bus.mem_rd, exp_rd);
      if (exp_rd) check("mem_addr", bus.mem_addr, m_issued);
      check("pix_valid", bus.pix_valid, m_valid);
      check("pix_data",  bus.pix_data,  m_data);
      check("underflow", bus.underflow, m_uf);
      if (bus.frame_start) begin
        m_fetch = 1; m_issued = 0; m_popped = 0; m_land.delete();
        m_valid = 1'b0; m_data = '0; m_uf = 1'b0;
      end else begin
        if (bus.pix_req) begin
          if (m_land.size() > 0 && m_land[0] <= m_cyc) begin
            m_valid = 1'b1;
            m_data  = PW'(m_popped);
            m_popped++;
            void'(m_land.pop_front());
          end else begin
            m_valid = 1'b0; m_data = '0; m_uf = 1'b1;
          end
        end else begin
          m_valid = 1'b0; m_data = '0;
        end
        if (exp_rd) begin
          m_land.push_back(m_cyc + LAT + 1);
          m_issued++;
        end
      end
    end
  end

  int            rd_pulses = 0;
  int            last_addr = 0;
  int            vcount    = 0;
  logic [PW-1:0] last_data = '0;

  task automatic step(input bit rst, input bit fs, input bit req);
    @(posedge clk);
    #1;
    rst_n           = rst;
    bus.frame_start = fs;
    bus.pix_req     = req;
    @(negedge clk);
    if (bus.mem_rd) begin
      rd_pulses++;
      last_addr = int'(bus.mem_addr);
    end
    if (bus.pix_valid) begin
      vcount++;
      last_data = bus.pix_data;
    end
  endtask

  task automatic cyc(input bit fs, input bit req);
    step(1'b1, fs, req);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_c, last_c, addr_err, seq_err;
    logic [PW-1:0] first_data;
    bus.frame_start = 1'b0;
    bus.pix_req     = 1'b0;
    first_data      = '1;

    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("reset_pix_valid", bus.pix_valid, 0);
    check("reset_mem_rd", bus.mem_rd, 0);

    // Request before any frame
    cyc(0, 0); cyc(0, 1); cyc(0, 0);
    check("preframe_underflow", bus.underflow, 1);
    check("preframe_valid", bus.pix_valid, 0);
    check("preframe_data", bus.pix_data, 0);
    check("preframe_no_reads", rd_pulses, 0);

    // Initial fill
    rd_pulses = 0;
    cyc(1, 0);
    check("fs_cycle_no_rd", rd_pulses, 0);
    first_c = -1; last_c = -1; addr_err = 0;
    for (int i = 1; i <= 30; i++) begin
      cyc(0, 0);
      if (bus.mem_rd) begin
        if (first_c < 0) first_c = i;
        last_c = i;
        if (int'(bus.mem_addr) != i - 1) addr_err++;
      end
    end
    check("fill_reads", rd_pulses, 16);
    check("fill_first_cycle", first_c, 1);
    check("fill_last_cycle", last_c, 16);
    check("fill_addr_seq", addr_err, 0);
    check("fs_clears_underflow", bus.underflow, 0);

    // Streaming one line
    vcount = 0; seq_err = 0;
    for (int i = 0; i < 800; i++) begin
      cyc(0, 1);
      if (i > 0) begin
        if (!bus.pix_valid || bus.pix_data != PW'(i - 1)) seq_err++;
        if (i == 1) first_data = bus.pix_data;
      end
    end
    cyc(0, 0);
    check("stream_first", first_data, 12'h000);
    check("stream_last", bus.pix_data, 12'h31F);
    check("stream_last_valid", bus.pix_valid, 1);
    check("stream_count", vcount, 800);
    check("stream_seq", seq_err, 0);
    check("stream_underflow", bus.underflow, 0);

    // Rest of the frame with random pacing
    for (int n = 0; n < 6000 && vcount < TOTAL; n++) cyc(0, $urandom_range(3, 0) != 0);
    check("frame_all_pixels", vcount, TOTAL);
    check("frame_last_pixel", last_data, 12'h4AF);
    repeat (20) cyc(0, 0);
    check("frame_read_count", rd_pulses, TOTAL);
    check("frame_last_addr", last_addr, 1199);
    cyc(0, 1); cyc(0, 0);
    check("eof_valid", bus.pix_valid, 0);
    check("eof_data", bus.pix_data, 0);
    check("eof_underflow", bus.underflow, 1);

    // Mid-frame restart with 5 FIFO entries and 2 reads in flight
    rd_pulses = 0;
    cyc(1, 0);
    repeat (7) cyc(0, 0);
    check("restart_reads_before", rd_pulses, 7);
    cyc(1, 0);
    repeat (25) cyc(0, 0);
    cyc(0, 1); cyc(0, 0);
    check("restart_first_valid", bus.pix_valid, 1);
    check("restart_first_data", bus.pix_data, 12'h000);
    repeat (40) cyc(0, $urandom_range(1, 0) != 0);

    // Reset during FETCH
    cyc(1, 0);
    cyc(0, 1);
    repeat (4) cyc(0, 0);
    check("prereset_underflow", bus.underflow, 1);
    check("prereset_mem_rd", bus.mem_rd, 1);
    step(1'b0, 1'b0, 1'b0);
    check("midreset_mem_rd", bus.mem_rd, 0);
    check("midreset_underflow", bus.underflow, 0);
    check("midreset_valid", bus.pix_valid, 0);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    rd_pulses = 0;
    repeat (12) cyc(0, 0);
    check("postreset_idle_reads", rd_pulses, 0);

    cyc(1, 0);
    repeat (60) cyc(0, $urandom_range(1, 0) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
